// File: rtl/regfile_scoreboard.sv
// Integer register file (x0 = 0) with a per-register busy scoreboard and a saturating write counter.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_dst,
    input  logic          wvalid,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    output logic          busy1,
    output logic          busy2,
    output logic          stall,
    output logic [31:0]   wcount
);

    logic [DW-1:0]   r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic [31:0]     r_wcount;

    logic            w_wr;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;
    logic [DW-1:0]   w_rd1;
    logic [DW-1:0]   w_rd2;
    logic            w_busy1;
    logic            w_busy2;

    assign w_wr = wvalid && (wa != '0);

    // Bit 0 is masked out of the set mask so x0 can never become busy.
    assign w_set = issue_valid ? ((NREG'(1) << issue_dst) & ~NREG'(1)) : '0;
    assign w_clr = w_wr ? (NREG'(1) << wa) : '0;

    for (genvar g = 0; g < NREG; g++) begin : g_reg
        always_ff @(posedge clk) begin
            if (!reset) begin
                r_regs[g] <= '0;
            end else if (w_wr && (wa == AW'(g))) begin
                r_regs[g] <= wd;
            end
        end
    end

    // Set is applied after clear so a new producer supersedes the retiring one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wcount <= '0;
        end else if (w_wr && (r_wcount != '1)) begin
            r_wcount <= r_wcount + 32'd1;
        end
    end

    always_comb begin
        w_rd1   = (ra1 == '0) ? '0 : r_regs[ra1];
        w_rd2   = (ra2 == '0) ? '0 : r_regs[ra2];
        w_busy1 = r_busy[ra1];
        w_busy2 = r_busy[ra2];
`ifdef REGFILE_BYPASS_EN
        // The in-flight write both supplies the data and resolves the hazard this cycle.
        if (w_wr && (wa == ra1)) begin
            w_rd1   = wd;
            w_busy1 = 1'b0;
        end
        if (w_wr && (wa == ra2)) begin
            w_rd2   = wd;
            w_busy2 = 1'b0;
        end
`else
`endif
    end

    assign rd1    = w_rd1;
    assign rd2    = w_rd2;
    assign busy1  = w_busy1;
    assign busy2  = w_busy2;
    assign stall  = w_busy1 | w_busy2;
    assign wcount = r_wcount;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reference model feeds an expectation queue,
// each DUT observation pops and compares against it.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ra1, ra2;
    logic [63:0] rd1, rd2;
    logic        issue_valid;
    logic [4:0]  issue_dst;
    logic        wvalid;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        busy1, busy2, stall;
    logic [31:0] wcount;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q[$];

    logic [63:0] m_regs [32];
    logic [31:0] m_busy;
    logic [31:0] m_wcount;

    regfile_scoreboard #(.NREG(32), .AW(5), .DW(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .ra1        (ra1),
        .ra2        (ra2),
        .rd1        (rd1),
        .rd2        (rd2),
        .issue_valid(issue_valid),
        .issue_dst  (issue_dst),
        .wvalid     (wvalid),
        .wa         (wa),
        .wd         (wd),
        .busy1      (busy1),
        .busy2      (busy2),
        .stall      (stall),
        .wcount     (wcount)
    );

    always #5 clk = ~clk;

    // Behavioural reference: what the architectural state should become at an edge.
    task automatic model_edge();
        logic [31:0] nb;
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_busy   = '0;
            m_wcount = '0;
        end else begin
            nb = m_busy;
            if (wvalid && wa != 5'd0) begin
                m_regs[wa] = wd;
                nb[wa] = 1'b0;
                if (m_wcount != 32'hFFFF_FFFF) m_wcount = m_wcount + 1;
            end
            if (issue_valid && issue_dst != 5'd0) nb[issue_dst] = 1'b1;
            m_busy = nb;
        end
    endtask

    function automatic logic [63:0] exp_rd(input logic [4:0] ra);
        if (ra == 5'd0) return 64'd0;
`ifdef REGFILE_BYPASS_EN
        if (wvalid && wa != 5'd0 && wa == ra) return wd;
`endif
        return m_regs[ra];
    endfunction

    function automatic logic exp_busy(input logic [4:0] ra);
`ifdef REGFILE_BYPASS_EN
        if (wvalid && wa != 5'd0 && wa == ra) return 1'b0;
`endif
        return m_busy[ra];
    endfunction

    task automatic push_exp(input logic [63:0] e);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs);
        logic [63:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s observed=%h expected=<none queued>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Compare every output against the reference model for the current inputs.
    task automatic probe(input string t);
        #1;
        push_exp(exp_rd(ra1));                        chk({t, ".rd1"}, rd1);
        push_exp(exp_rd(ra2));                        chk({t, ".rd2"}, rd2);
        push_exp({63'd0, exp_busy(ra1)});             chk({t, ".busy1"}, {63'd0, busy1});
        push_exp({63'd0, exp_busy(ra2)});             chk({t, ".busy2"}, {63'd0, busy2});
        push_exp({63'd0, exp_busy(ra1) | exp_busy(ra2)}); chk({t, ".stall"}, {63'd0, stall});
        push_exp({32'd0, m_wcount});                  chk({t, ".wcount"}, {32'd0, wcount});
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_dst = '0;
        wvalid = 1'b0; wa = '0; wd = '0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 64'hDEAD_BEEF;
        m_busy = 32'hFFFF_FFFF; m_wcount = 32'hFFFF_FFFF;
        ra1 = 5'd5; ra2 = 5'd5;

        // Reset held two cycles while a write and an issue are presented
        reset = 1'b0;
        wvalid = 1'b1; wa = 5'd5; wd = 64'hAA;
        issue_valid = 1'b1; issue_dst = 5'd5;
        tick(); tick();
        reset = 1'b1; idle_inputs();
        probe("rst");
        push_exp(64'd0); chk("rst.rd1_x5", rd1);
        push_exp(64'd0); chk("rst.stall", {63'd0, stall});
        push_exp(64'd0); chk("rst.wcount", {32'd0, wcount});

        // Write to x0 is dropped
        wvalid = 1'b1; wa = 5'd0; wd = 64'hFF;
        tick();
        idle_inputs(); ra1 = 5'd0; ra2 = 5'd0;
        probe("x0");
        push_exp(64'd0); chk("x0.rd1", rd1);
        push_exp(64'd0); chk("x0.wcount", {32'd0, wcount});

        // Issue x7, then resolve it with a writeback
        issue_valid = 1'b1; issue_dst = 5'd7; ra1 = 5'd7;
        #1;
        push_exp(64'd0); chk("iss7.no_self_stall", {63'd0, stall});
        tick();
        idle_inputs();
        probe("busy7");
        push_exp(64'd1); chk("busy7.busy1", {63'd0, busy1});
        push_exp(64'd1); chk("busy7.stall", {63'd0, stall});
        wvalid = 1'b1; wa = 5'd7; wd = 64'h1234;
        probe("wb7");
`ifdef REGFILE_BYPASS_EN
        push_exp(64'h1234); chk("wb7.rd1_fwd", rd1);
        push_exp(64'd0);    chk("wb7.stall_fwd", {63'd0, stall});
`else
        push_exp(64'd0);    chk("wb7.rd1_old", rd1);
        push_exp(64'd1);    chk("wb7.stall_held", {63'd0, stall});
`endif
        tick();
        idle_inputs();
        probe("post7");
        push_exp(64'h1234); chk("post7.rd1", rd1);
        push_exp(64'd0);    chk("post7.busy1", {63'd0, busy1});
        push_exp(64'd1);    chk("post7.wcount", {32'd0, wcount});

        // Same-cycle issue and write to x3: set wins, data lands
        issue_valid = 1'b1; issue_dst = 5'd3;
        wvalid = 1'b1; wa = 5'd3; wd = 64'h3333;
        tick();
        idle_inputs(); ra1 = 5'd0; ra2 = 5'd3;
        probe("set_wins");
        push_exp(64'd1);    chk("set_wins.busy2", {63'd0, busy2});
        push_exp(64'h3333); chk("set_wins.rd2", rd2);

        // Both ports read the same clean register
        wvalid = 1'b1; wa = 5'd9; wd = 64'h55;
        tick();
        idle_inputs(); ra1 = 5'd9; ra2 = 5'd9;
        probe("dual9");
        push_exp(64'h55); chk("dual9.rd1", rd1);
        push_exp(64'h55); chk("dual9.rd2", rd2);
        push_exp(64'd0);  chk("dual9.stall", {63'd0, stall});

        // Reset pulse, then 40 counted writes spread over x1..x31
        reset = 1'b0; tick(); reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wvalid = 1'b1; wa = 5'((i % 31) + 1); wd = {$urandom, $urandom};
            tick();
        end
        idle_inputs(); ra1 = 5'd12; ra2 = 5'd31;
        probe("w40");
        push_exp(64'd40); chk("w40.wcount", {32'd0, wcount});

        // Mark registers busy, then reset while a write and an issue are presented
        issue_valid = 1'b1; issue_dst = 5'd4; tick();
        issue_dst = 5'd6; tick();
        idle_inputs(); ra1 = 5'd4; ra2 = 5'd6;
        probe("busy46");
        reset = 1'b0;
        wvalid = 1'b1; wa = 5'd4; wd = 64'h77;
        issue_valid = 1'b1; issue_dst = 5'd8;
        tick();
        reset = 1'b1; idle_inputs(); ra2 = 5'd8;
        probe("midrst");
        push_exp(64'd0); chk("midrst.wcount", {32'd0, wcount});
        push_exp(64'd0); chk("midrst.stall", {63'd0, stall});
        push_exp(64'd0); chk("midrst.rd1", rd1);

        // Write to a non-busy register neither sets busy nor disturbs others
        wvalid = 1'b1; wa = 5'd31; wd = 64'hCAFE;
        tick();
        idle_inputs(); ra1 = 5'd31; ra2 = 5'd0;
        probe("link31");
        push_exp(64'hCAFE); chk("link31.rd1", rd1);
        push_exp(64'd0);    chk("link31.busy1", {63'd0, busy1});

        if (exp_q.size() != 0) begin
            failures++;
            $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
